// File: rtl/mem_reader_ctrl.sv
// Request/response sequencer for the JK-flip-flop word memories.
// Define MEM_READER_CTRL_VERIFY_EN to add a readback check after each write.
module mem_reader_ctrl #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [DEPTH-1:0]  mem_add,
  output logic              mem_rw,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DEPTH-1:0]   mem_add_q, mem_add_d;
  logic               mem_rw_q, mem_rw_d;
  logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
`ifdef MEM_READER_CTRL_VERIFY_EN
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic               wr_q, wr_d;
`endif

  function automatic logic [DEPTH-1:0] onehot(
    input logic [ADDR_W-1:0] a
  );
    logic [DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v[i] = (int'(a) == i);
    end
    return v;
  endfunction

  logic in_range;
  assign in_range = int'(req_addr) < DEPTH;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_add_d   = mem_add_q;
    mem_rw_d    = mem_rw_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_READER_CTRL_VERIFY_EN
    wdata_d     = wdata_q;
    wr_d        = wr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
`ifdef MEM_READER_CTRL_VERIFY_EN
          wdata_d     = req_data;
          wr_d        = req_rw;
`endif
          if (!in_range) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else if (req_rw) begin
            state_d     = S_WRITE;
            mem_add_d   = onehot(req_addr);
            mem_rw_d    = 1'b1;
            mem_wdata_d = req_data;
          end else begin
            state_d     = S_READ;
            mem_add_d   = onehot(req_addr);
          end
        end
      end
      S_WRITE: begin
        mem_rw_d    = 1'b0;
        mem_wdata_d = '0;
`ifdef MEM_READER_CTRL_VERIFY_EN
        // keep the word selected and read it straight back
        state_d     = S_READ;
`else
        state_d     = S_RESP;
        mem_add_d   = '0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
`endif
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d     = S_RESP;
        mem_add_d   = '0;
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_rdata;
`ifdef MEM_READER_CTRL_VERIFY_EN
        rsp_err_d   = wr_q && (mem_rdata != wdata_q);
`else
        rsp_err_d   = 1'b0;
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        mem_add_d   = '0;
        mem_rw_d    = 1'b0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_add_q   <= '0;
      mem_rw_q    <= 1'b0;
      mem_wdata_q <= '0;
`ifdef MEM_READER_CTRL_VERIFY_EN
      wdata_q     <= '0;
      wr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_add_q   <= mem_add_d;
      mem_rw_q    <= mem_rw_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_READER_CTRL_VERIFY_EN
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_add   = mem_add_q;
  assign mem_rw    = mem_rw_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_reader_ctrl.sv
// Randomized bench for mem_reader_ctrl against a word-level memory model.
// DEPTH=3 so that address 3 exercises the out-of-range path.
module tb_mem_reader_ctrl;

  localparam int W = 4;
  localparam int D = 3;
  localparam int A = 2;

`ifdef MEM_READER_CTRL_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_rw = 1'b0;
  logic [A-1:0] req_addr = '0;
  logic [W-1:0] req_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic [D-1:0] mem_add;
  logic         mem_rw;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] store [D];
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] stuck = '0;

  always #5 clk = ~clk;

  mem_reader_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr),
    .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_add(mem_add), .mem_rw(mem_rw),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < D; i++)
      if (mem_add[i]) mem_rdata = mem_rdata | store[i];
  end

  always @(posedge clk) begin
    if (mem_rw)
      for (int i = 0; i < D; i++)
        if (mem_add[i]) store[i] <= mem_wdata & ~stuck;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (clear) begin
      chk("add_1hot", 32'($countones(mem_add) > 1), 0);
      chk("rw_1hot",
          32'(mem_rw && ($countones(mem_add) != 1)), 0);
    end
  end

  task automatic txn(input bit rw, input logic [A-1:0] a,
                     input logic [W-1:0] d, input int stall);
    int lat, nrw, nadd, nhit;
    int exp_lat, exp_add;
    logic [W-1:0] exp_d, stored;
    logic [D-1:0] oh;
    bit exp_e, oor;
    oor = int'(a) >= D;
    oh = '0;
    if (!oor) oh[a] = 1'b1;
    stored = d & ~stuck;
    if (oor) begin
      exp_lat = 1; exp_add = 0; exp_d = '0; exp_e = 1'b1;
    end else if (rw) begin
      exp_lat = VFY ? 4 : 2;
      exp_add = VFY ? 3 : 1;
      exp_d   = VFY ? stored : '0;
      exp_e   = VFY && (stored != d);
    end else begin
      exp_lat = 3; exp_add = 2;
      exp_d = ref_mem[a]; exp_e = 1'b0;
    end
    if (rw && !oor) ref_mem[a] = stored;

    chk("idle_rdy", req_ready, 1);
    req_valid = 1'b1; req_rw = rw;
    req_addr = a; req_data = d; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; nrw = 0; nadd = 0; nhit = 0;
    while (!rsp_valid && lat <= 8) begin
      chk("busy_rdy", req_ready, 0);
      if (mem_rw) begin
        nrw++;
        chk("wdata", mem_wdata, d);
      end
      if (mem_add != '0) nadd++;
      if (mem_add == oh) nhit++;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("strobes", nrw, (rw && !oor) ? 1 : 0);
    chk("add_cyc", nadd, exp_add);
    chk("add_hit", nhit, exp_add);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", rsp_err, exp_e);
    chk("rsp_add0", mem_add, 0);
    chk("rsp_rw0", mem_rw, 0);
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_rw = 1'($urandom);
      req_addr = A'($urandom);
      @(negedge clk);
      chk("hold_v", rsp_valid, 1);
      chk("hold_d", rsp_data, exp_d);
      chk("hold_e", rsp_err, exp_e);
      chk("hold_rdy", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_v", rsp_valid, 0);
    chk("done_rdy", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      store[i] = '0;
      ref_mem[i] = '0;
    end
    #12;
    chk("rst_rdy", req_ready, 1);
    chk("rst_v", rsp_valid, 0);
    chk("rst_d", rsp_data, 0);
    chk("rst_e", rsp_err, 0);
    chk("rst_add", mem_add, 0);
    chk("rst_rw", mem_rw, 0);
    chk("rst_wd", mem_wdata, 0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);

    txn(1'b1, 2'd1, 4'b0101, 0);
    txn(1'b0, 2'd1, 4'b0000, 0);
    txn(1'b0, 2'd1, 4'b0000, 5);
    txn(1'b0, 2'd3, 4'b1111, 0);
    txn(1'b1, 2'd3, 4'b1010, 2);
    txn(1'b1, 2'd2, 4'b0011, 0);

    // clear during the write strobe: nothing may reach the array
    chk("idle_rdy", req_ready, 1);
    req_valid = 1'b1; req_rw = 1'b1;
    req_addr = 2'd2; req_data = 4'b1100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_rw", mem_rw, 1);
    #2 clear = 1'b0;
    #1;
    chk("arst_add", mem_add, 0);
    chk("arst_rw", mem_rw, 0);
    chk("arst_wd", mem_wdata, 0);
    chk("arst_v", rsp_valid, 0);
    chk("arst_rdy", req_ready, 1);
    @(negedge clk);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_v", rsp_valid, 0);
      chk("post_rdy", req_ready, 1);
    end
    txn(1'b0, 2'd2, 4'b0000, 0);

    stuck = 4'b1000;
    txn(1'b1, 2'd0, 4'b1110, 0);
    txn(1'b0, 2'd0, 4'b0000, 1);
    stuck = '0;

    for (int n = 0; n < 60; n++) begin
      txn(1'($urandom), A'($urandom), W'($urandom),
          int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
